dm_port_arbiter: RTL and testbench

Shares the single data-memory port of `memory` between the processor core's data-address path and a host/debug requester. Each cycle it decides which requester drives `ps_dm_cslt`/`ps_dm_wrb`/`dg_dm_add`. It steers the delayed write data onto `bc_dt` and returns `dm_bc_dt` to whichever requester issued the read. The core has fixed priority, and a counter guarantees the host forward progress.

---
 rtl/dm_arb_pkg.sv | 11 +
 rtl/dm_arb_starve_ctr.sv | 30 +++
 rtl/dm_port_arbiter.sv | 100 ++++++++++
 tb/tb_dm_port_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter and its memory.
package dm_arb_pkg;
    localparam int DMA_SIZE = 17;
    localparam int DMD_SIZE = 16;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CORE = 2'd1,
        HOST = 2'd2
    } owner_t;
endpackage

// File: rtl/dm_arb_starve_ctr.sv
// Saturating count of consecutive cycles the host was blocked by the core;
// force_host lets the host through once the limit is reached.
module dm_arb_starve_ctr
    import dm_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   hst_req,
    input  owner_t owner,
    output logic   force_host
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (!hst_req || owner == HOST) begin
            cnt <= '0;
        end else if (owner == CORE && cnt != LIMIT) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign force_host = hst_req && (cnt == LIMIT);
endmodule

// File: rtl/dm_port_arbiter.sv
// Shares the single DM port between the core (fixed priority) and the host,
// routing delayed write data and read returns to the requester that owned the access.
module dm_port_arbiter
    import dm_arb_pkg::*;
#(
    parameter int DMA_SIZE     = dm_arb_pkg::DMA_SIZE,
    parameter int DMD_SIZE     = dm_arb_pkg::DMD_SIZE,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                core_req,
    input  logic                core_wrb,
    input  logic [DMA_SIZE-1:0] core_add,
    input  logic [DMD_SIZE-1:0] core_wdata,
    output logic                core_stall,
    output logic [DMD_SIZE-1:0] core_rdata,
    output logic                core_rvalid,
    input  logic                hst_req,
    input  logic                hst_wrb,
    input  logic [DMA_SIZE-1:0] hst_add,
    input  logic [DMD_SIZE-1:0] hst_wdata,
    output logic                hst_gnt,
    output logic [DMD_SIZE-1:0] hst_rdata,
    output logic                hst_rvalid,
    output logic                ps_dm_cslt,
    output logic                ps_dm_wrb,
    output logic [DMA_SIZE-1:0] dg_dm_add,
    output logic [DMD_SIZE-1:0] bc_dt,
    input  logic [DMD_SIZE-1:0] dm_bc_dt
);
    owner_t owner;
    owner_t wr_owner;
    owner_t rd_owner;
    logic   force_host;

    dm_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk       (clk),
        .reset     (reset),
        .hst_req   (hst_req),
        .owner     (owner),
        .force_host(force_host)
    );

    always_comb begin
        owner = NONE;
        if (force_host)    owner = HOST;
        else if (core_req) owner = CORE;
        else if (hst_req)  owner = HOST;
    end

    always_comb begin
        ps_dm_cslt = 1'b0;
        ps_dm_wrb  = 1'b0;
        dg_dm_add  = '0;
        case (owner)
            CORE: begin
                ps_dm_cslt = 1'b1;
                ps_dm_wrb  = core_wrb;
                dg_dm_add  = core_add;
            end
            HOST: begin
                ps_dm_cslt = 1'b1;
                ps_dm_wrb  = hst_wrb;
                dg_dm_add  = hst_add;
            end
            default: ;
        endcase
    end

    assign core_stall = core_req && (owner != CORE);
    assign hst_gnt    = (owner == HOST);

    // Data phase trails the address phase by one cycle; a NONE owner yields wrb=0 and cslt=0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_owner <= NONE;
            rd_owner <= NONE;
        end else begin
            wr_owner <= ps_dm_wrb ? owner : NONE;
            rd_owner <= (ps_dm_cslt && !ps_dm_wrb) ? owner : NONE;
        end
    end

    always_comb begin
        bc_dt = '0;
        case (wr_owner)
            CORE:    bc_dt = core_wdata;
            HOST:    bc_dt = hst_wdata;
            default: ;
        endcase
    end

    assign core_rvalid = (rd_owner == CORE);
    assign hst_rvalid  = (rd_owner == HOST);
    assign core_rdata  = dm_bc_dt;
    assign hst_rdata   = dm_bc_dt;
endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter with a small DM model and a grant-rule reference.
module tb_dm_port_arbiter;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_wrb, hst_req, hst_wrb;
    logic [16:0] core_add, hst_add, dg_dm_add;
    logic [15:0] core_wdata, hst_wdata, core_rdata, hst_rdata, bc_dt, dm_bc_dt;
    logic        core_stall, core_rvalid, hst_gnt, hst_rvalid, ps_dm_cslt, ps_dm_wrb;

    dm_port_arbiter #(
        .DMA_SIZE(17),
        .DMD_SIZE(16),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_wrb(core_wrb), .core_add(core_add), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .hst_req(hst_req), .hst_wrb(hst_wrb), .hst_add(hst_add), .hst_wdata(hst_wdata),
        .hst_gnt(hst_gnt), .hst_rdata(hst_rdata), .hst_rvalid(hst_rvalid),
        .ps_dm_cslt(ps_dm_cslt), .ps_dm_wrb(ps_dm_wrb), .dg_dm_add(dg_dm_add),
        .bc_dt(bc_dt), .dm_bc_dt(dm_bc_dt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        int          due;
    } rd_t;

    rd_t         cq[$];
    rd_t         hq[$];
    rd_t         mt;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          waited = 0;
    logic [15:0] mem_m[32];
    logic        pend_v = 1'b0;
    logic        pend_core = 1'b0;
    logic [15:0] pend_d = '0;
    logic        cev, hev;

    function automatic logic [15:0] init_val(input int i);
        return (i == 10) ? 16'h1234 : 16'((i * 16'h0101) ^ 16'hC3A5);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // DM model: address sampled at posedge, read data one cycle later, write committed
    // at the end of the data phase, with bypass of the committing write to a same-address read.
    logic [15:0] env_mem[32];
    logic        mem_ready = 1'b0;
    logic        wp = 1'b0;
    logic [4:0]  wa = '0;
    logic [15:0] rdq = '0;
    assign dm_bc_dt = rdq;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!mem_ready) begin
            for (int i = 0; i < 32; i++) env_mem[i] <= init_val(i);
            mem_ready <= 1'b1;
        end else begin
            if (wp && reset) env_mem[wa] <= bc_dt;
            if (ps_dm_cslt && !ps_dm_wrb)
                rdq <= (wp && reset && wa == dg_dm_add[4:0]) ? bc_dt : env_mem[dg_dm_add[4:0]];
        end
        wp <= reset && ps_dm_cslt && ps_dm_wrb;
        wa <= dg_dm_add[4:0];
    end

    // Monitor: read returns must appear exactly one cycle after the grant, to the right requester.
    always @(negedge clk) begin
        cev = (cq.size() > 0) && (cq[0].due == cyc);
        hev = (hq.size() > 0) && (hq[0].due == cyc);
        chk("core_rvalid", core_rvalid, cev);
        chk("hst_rvalid", hst_rvalid, hev);
        if (cev) begin
            mt = cq.pop_front();
            chk("core_rdata", core_rdata, mt.d);
        end
        if (hev) begin
            mt = hq.pop_front();
            chk("hst_rdata", hst_rdata, mt.d);
        end
    end

    // One cycle of stimulus, entered and left at posedge+1.
    task automatic step(input logic creq, input logic cwrb, input logic [16:0] cadd, input logic [15:0] cwd,
                        input logic hreq, input logic hwrb, input logic [16:0] hadd, input logic [15:0] hwd,
                        output logic hg, output logic cs);
        logic        eh, ec, wr;
        logic [16:0] a;
        logic [15:0] eb;
        rd_t         e;
        core_req = creq; core_wrb = cwrb; core_add = cadd;
        hst_req  = hreq; hst_wrb  = hwrb; hst_add  = hadd;
        core_wdata = (pend_v && pend_core)  ? pend_d : 16'($urandom);
        hst_wdata  = (pend_v && !pend_core) ? pend_d : 16'($urandom);
        eb = pend_v ? pend_d : 16'h0000;
        eh = hreq && (waited >= LIMIT || !creq);
        ec = creq && !eh;
        #1;
        chk("hst_gnt", hst_gnt, eh);
        chk("core_stall", core_stall, creq && !ec);
        chk("ps_dm_cslt", ps_dm_cslt, eh || ec);
        chk("ps_dm_wrb", ps_dm_wrb, eh ? hwrb : (ec ? cwrb : 1'b0));
        chk("dg_dm_add", dg_dm_add, eh ? hadd : (ec ? cadd : 17'd0));
        chk("bc_dt", bc_dt, eb);
        hg = hst_gnt;
        cs = core_stall;
        waited = (eh || !hreq) ? 0 : waited + 1;
        pend_v = 1'b0;
        if (eh || ec) begin
            wr = eh ? hwrb : cwrb;
            a  = eh ? hadd : cadd;
            if (wr) begin
                pend_v = 1'b1;
                pend_core = ec;
                pend_d = eh ? hwd : cwd;
                mem_m[a[4:0]] = pend_d;
            end else begin
                e.d = mem_m[a[4:0]];
                e.due = cyc + 1;
                if (ec) cq.push_back(e);
                else hq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        hg, cs;
        logic        cr, cw, hr, hw;
        logic [16:0] ca, ha;
        logic [15:0] cd, hd;
        int          gnts[$];
        int          pc;

        for (int i = 0; i < 32; i++) mem_m[i] = init_val(i);
        reset = 1'b0;
        core_req = 0; core_wrb = 0; core_add = '0; core_wdata = '0;
        hst_req = 0; hst_wrb = 0; hst_add = '0; hst_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cslt", ps_dm_cslt, 0);
        chk("rst_wrb", ps_dm_wrb, 0);
        chk("rst_add", dg_dm_add, 0);
        chk("rst_bc_dt", bc_dt, 0);
        chk("rst_stall", core_stall, 0);
        chk("rst_gnt", hst_gnt, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Core read of the preloaded word, then host write/read-back of 0xF.
        step(1, 0, 17'h0000A, 16'h0, 0, 0, 17'h0, 16'h0, hg, cs);
        step(0, 0, 17'h0, 16'h0, 1, 1, 17'h0000F, 16'hFFEE, hg, cs);
        step(0, 0, 17'h0, 16'h0, 0, 0, 17'h0, 16'h0, hg, cs);
        step(0, 0, 17'h0, 16'h0, 1, 0, 17'h0000F, 16'h0, hg, cs);
        step(0, 0, 17'h0, 16'h0, 0, 0, 17'h0, 16'h0, hg, cs);

        // Continuous contention: host forced through on cycles 9 and 18.
        for (int i = 1; i <= 18; i++) begin
            step(1, 0, 17'(i % 32), 16'h0, 1, 0, 17'd5, 16'h0, hg, cs);
            if (hg) gnts.push_back(i);
        end
        chk("starve_grants", gnts.size(), 2);
        if (gnts.size() >= 2) begin
            chk("starve_first", gnts[0], 9);
            chk("starve_second", gnts[1], 18);
        end
        step(0, 0, 17'h0, 16'h0, 0, 0, 17'h0, 16'h0, hg, cs);

        // Host write then core read of the same address on the next cycle.
        step(0, 0, 17'h0, 16'h0, 1, 1, 17'h00003, 16'hAAAA, hg, cs);
        step(1, 0, 17'h00003, 16'h0, 0, 0, 17'h0, 16'h0, hg, cs);
        step(0, 0, 17'h0, 16'h0, 0, 0, 17'h0, 16'h0, hg, cs);

        // Reset during the data phase of a host read drops the return.
        step(0, 0, 17'h0, 16'h0, 1, 0, 17'h00007, 16'h0, hg, cs);
        reset = 1'b0;
        core_req = 0; hst_req = 0; core_wrb = 0; hst_wrb = 0; core_add = '0; hst_add = '0;
        cq.delete(); hq.delete();
        pend_v = 1'b0; waited = 0;
        #1;
        chk("midrst_hst_rvalid", hst_rvalid, 0);
        chk("midrst_core_rvalid", core_rvalid, 0);
        chk("midrst_cslt", ps_dm_cslt, 0);
        chk("midrst_bc_dt", bc_dt, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1, 0, 17'h00004, 16'h0, 0, 0, 17'h0, 16'h0, hg, cs);
        chk("post_rst_no_stall", cs, 0);

        // Alternating core write / host read with no idle cycles.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) step(1, 1, 17'(i + 16), 16'($urandom), 0, 0, 17'h0, 16'h0, hg, cs);
            else            step(0, 0, 17'h0, 16'h0, 1, 0, 17'(i + 15), 16'h0, hg, cs);
        end

        // Random traffic respecting the hold rules of both requesters.
        cr = 0; cw = 0; ca = '0; cd = '0; hr = 0; hw = 0; ha = '0; hd = '0;
        hg = 0; cs = 0;
        for (int i = 0; i < 2000; i++) begin
            pc = (i < 1000) ? 65 : 92;
            if (!cr || !cs) begin
                cr = ($urandom_range(0, 99) < pc);
                cw = 1'($urandom_range(0, 1));
                ca = 17'($urandom_range(0, 31));
                cd = 16'($urandom);
            end
            if (!hr || hg) begin
                hr = ($urandom_range(0, 99) < 45);
                hw = 1'($urandom_range(0, 1));
                ha = 17'($urandom_range(0, 31));
                hd = 16'($urandom);
            end
            step(cr, cw, ca, cd, hr, hw, ha, hd, hg, cs);
        end

        repeat (3) step(0, 0, 17'h0, 16'h0, 0, 0, 17'h0, 16'h0, hg, cs);
        chk("core_q_drained", cq.size(), 0);
        chk("hst_q_drained", hq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
